multicycle_control: RTL and testbench

Main control unit for the multi-cycle variant of the processor. A Moore-style FSM that sequences each instruction through fetch, decode, execute, memory and write-back steps. It drives every datapath enable and mux select, and produces the 2-bit `ALUOp` consumed by the ALU control decoder. Memory accesses use a `mem_ready` handshake, so the FSM stalls on slow memory.

---
 rtl/ctrl_pkg.sv | 46 ++++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/multicycle_control.sv | 144 ++++++++++++++
 tb/tb_multicycle_control.sv | 159 +++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// Shared constants for the multi-cycle control path: FSM state encodings,
// opcodes, ALUOp codes (shared with the ALU control decoder) and mux selects.
package ctrl_pkg;

   typedef enum logic [3:0] {
      StReset    = 4'd0,
      StFetch    = 4'd1,
      StDecode   = 4'd2,
      StMemAddr  = 4'd3,
      StMemRead  = 4'd4,
      StMemWb    = 4'd5,
      StMemWrite = 4'd6,
      StExecute  = 4'd7,
      StRComplete = 4'd8,
      StBranch   = 4'd9,
      StJump     = 4'd10,
      StAddiExec = 4'd11,
      StAddiWb   = 4'd12
   } state_e;

   localparam logic [5:0] OpRtype = 6'b000000;
   localparam logic [5:0] OpLw    = 6'b100011;
   localparam logic [5:0] OpSw    = 6'b101011;
   localparam logic [5:0] OpBeq   = 6'b000100;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpAddi  = 6'b001000;

   localparam logic [1:0] AluOpAdd   = 2'b00;
   localparam logic [1:0] AluOpSub   = 2'b01;
   localparam logic [1:0] AluOpFunct = 2'b10;

   localparam logic [1:0] SrcBRt    = 2'b00;
   localparam logic [1:0] SrcBFour  = 2'b01;
   localparam logic [1:0] SrcBImm   = 2'b10;
   localparam logic [1:0] SrcBImmSh = 2'b11;

   localparam logic [1:0] PcSrcAlu    = 2'b00;
   localparam logic [1:0] PcSrcAluOut = 2'b01;
   localparam logic [1:0] PcSrcJump   = 2'b10;

   // True for the load/store opcodes that share the address-compute step.
   function automatic logic is_mem_op(input logic [5:0] op);
      return (op == OpLw) || (op == OpSw);
   endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control-unit bundle: instruction/memory status in, datapath controls out.
interface multicycle_control_if;

   logic [5:0] opcode;
   logic       mem_ready;
   logic       PCWrite;
   logic       PCWriteCond;
   logic       IorD;
   logic       MemRead;
   logic       MemWrite;
   logic       IRWrite;
   logic       MemtoReg;
   logic       RegDst;
   logic       RegWrite;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ALUOp;
   logic [1:0] PCSource;
   logic       illegal_op;
   logic [3:0] state;

   // Control unit side.
   modport master (
      input  opcode, mem_ready,
      output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state
   );

   // Datapath side.
   modport slave (
      output opcode, mem_ready,
      input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, MemtoReg, RegDst,
             RegWrite, ALUSrcA, ALUSrcB, ALUOp, PCSource, illegal_op, state
   );

endinterface

// File: rtl/multicycle_control.sv
// Moore-style main control FSM for the multi-cycle processor. Outputs decode
// from the state register; only FETCH IRWrite/PCWrite follow mem_ready.
module multicycle_control
   import ctrl_pkg::*;
(
   input logic                  clk,
   input logic                  reset,
   multicycle_control_if.master bus
);

   state_e state_q, state_d;
   logic   illegal_q, illegal_d;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= StReset;
      end else begin
         state_q <= state_d;
      end
   end

   // Registered one-cycle pulse for an unsupported opcode seen in DECODE.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         illegal_q <= 1'b0;
      end else begin
         illegal_q <= illegal_d;
      end
   end

   // Next-state logic.
   always_comb begin
      state_d   = StFetch;
      illegal_d = 1'b0;
      case (state_q)
         StReset: state_d = StFetch;
         StFetch: state_d = bus.mem_ready ? StDecode : StFetch;
         StDecode: begin
            if (is_mem_op(bus.opcode)) begin
               state_d = StMemAddr;
            end else begin
               case (bus.opcode)
                  OpRtype: state_d = StExecute;
                  OpBeq:   state_d = StBranch;
                  OpJ:     state_d = StJump;
                  OpAddi:  state_d = StAddiExec;
                  default: begin
                     state_d   = StFetch;
                     illegal_d = 1'b1;
                  end
               endcase
            end
         end
         // Opcode is re-sampled here; anything other than sw takes the load path.
         StMemAddr:   state_d = (bus.opcode == OpSw) ? StMemWrite : StMemRead;
         StMemRead:   state_d = bus.mem_ready ? StMemWb : StMemRead;
         StMemWb:     state_d = StFetch;
         StMemWrite:  state_d = bus.mem_ready ? StFetch : StMemWrite;
         StExecute:   state_d = StRComplete;
         StRComplete: state_d = StFetch;
         StBranch:    state_d = StFetch;
         StJump:      state_d = StFetch;
         StAddiExec:  state_d = StAddiWb;
         StAddiWb:    state_d = StFetch;
         // Unused encodings recover to FETCH without flagging illegal_op.
         default:     state_d = StFetch;
      endcase
   end

   // Output decode.
   always_comb begin
      bus.PCWrite     = 1'b0;
      bus.PCWriteCond = 1'b0;
      bus.IorD        = 1'b0;
      bus.MemRead     = 1'b0;
      bus.MemWrite    = 1'b0;
      bus.IRWrite     = 1'b0;
      bus.MemtoReg    = 1'b0;
      bus.RegDst      = 1'b0;
      bus.RegWrite    = 1'b0;
      bus.ALUSrcA     = 1'b0;
      bus.ALUSrcB     = SrcBRt;
      bus.ALUOp       = AluOpAdd;
      bus.PCSource    = PcSrcAlu;
      case (state_q)
         StFetch: begin
            bus.MemRead  = 1'b1;
            bus.ALUSrcB  = SrcBFour;
            bus.IRWrite  = bus.mem_ready;
            bus.PCWrite  = bus.mem_ready;
         end
         StDecode: begin
            bus.ALUSrcB = SrcBImmSh;
         end
         StMemAddr: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = SrcBImm;
         end
         StMemRead: begin
            bus.MemRead = 1'b1;
            bus.IorD    = 1'b1;
         end
         StMemWb: begin
            bus.RegWrite = 1'b1;
            bus.MemtoReg = 1'b1;
         end
         StMemWrite: begin
            bus.MemWrite = 1'b1;
            bus.IorD     = 1'b1;
         end
         StExecute: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUOp   = AluOpFunct;
         end
         StRComplete: begin
            bus.RegWrite = 1'b1;
            bus.RegDst   = 1'b1;
         end
         StBranch: begin
            bus.ALUSrcA     = 1'b1;
            bus.ALUOp       = AluOpSub;
            bus.PCWriteCond = 1'b1;
            bus.PCSource    = PcSrcAluOut;
         end
         StJump: begin
            bus.PCWrite  = 1'b1;
            bus.PCSource = PcSrcJump;
         end
         StAddiExec: begin
            bus.ALUSrcA = 1'b1;
            bus.ALUSrcB = SrcBImm;
         end
         StAddiWb: begin
            bus.RegWrite = 1'b1;
         end
         default: ;
      endcase
   end

   assign bus.state      = state_q;
   assign bus.illegal_op = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: walks each instruction class through
// the FSM and compares state and the packed control word against hand values.
module tb_multicycle_control;

   logic clk = 1'b0;
   logic reset;
   int   n_checks = 0;
   int   n_pass   = 0;

   multicycle_control_if u_if ();

   multicycle_control u_dut (
      .clk   (clk),
      .reset (reset),
      .bus   (u_if.master)
   );

   always #5 clk = ~clk;

   // Packed order: PCWrite PCWriteCond IorD MemRead MemWrite IRWrite MemtoReg RegDst
   //               RegWrite ALUSrcA ALUSrcB[1:0] ALUOp[1:0] PCSource[1:0] illegal_op
   logic [16:0] outs;
   assign outs = {u_if.PCWrite, u_if.PCWriteCond, u_if.IorD, u_if.MemRead, u_if.MemWrite,
                  u_if.IRWrite, u_if.MemtoReg, u_if.RegDst, u_if.RegWrite, u_if.ALUSrcA,
                  u_if.ALUSrcB, u_if.ALUOp, u_if.PCSource, u_if.illegal_op};

   localparam logic [16:0] VZero     = 17'b0_0_0_0_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] VFetch    = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_0;
   localparam logic [16:0] VFetchStl = 17'b0_0_0_1_0_0_0_0_0_0_01_00_00_0;
   localparam logic [16:0] VFetchIll = 17'b1_0_0_1_0_1_0_0_0_0_01_00_00_1;
   localparam logic [16:0] VDecode   = 17'b0_0_0_0_0_0_0_0_0_0_11_00_00_0;
   localparam logic [16:0] VMemAddr  = 17'b0_0_0_0_0_0_0_0_0_1_10_00_00_0;
   localparam logic [16:0] VMemRead  = 17'b0_0_1_1_0_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] VMemWb    = 17'b0_0_0_0_0_0_1_0_1_0_00_00_00_0;
   localparam logic [16:0] VMemWrite = 17'b0_0_1_0_1_0_0_0_0_0_00_00_00_0;
   localparam logic [16:0] VExecute  = 17'b0_0_0_0_0_0_0_0_0_1_00_10_00_0;
   localparam logic [16:0] VRComp    = 17'b0_0_0_0_0_0_0_1_1_0_00_00_00_0;
   localparam logic [16:0] VBranch   = 17'b0_1_0_0_0_0_0_0_0_1_00_01_01_0;
   localparam logic [16:0] VJump     = 17'b1_0_0_0_0_0_0_0_0_0_00_00_10_0;
   localparam logic [16:0] VAddiWb   = 17'b0_0_0_0_0_0_0_0_1_0_00_00_00_0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle on freshly driven inputs, then compare.
   task automatic expect_st(input string tag, input logic [3:0] st, input logic [16:0] vec);
      #1;
      check({tag, "_state"}, 32'(u_if.state), 32'(st));
      check({tag, "_outs"}, 32'(outs), 32'(vec));
   endtask

   initial begin
      reset          = 1'b1;
      u_if.opcode    = 6'b100011;
      u_if.mem_ready = 1'b1;
      #2;
      expect_st("reset", 4'd0, VZero);
      @(negedge clk);
      reset = 1'b0;
      #1;
      expect_st("reset_hold", 4'd0, VZero);

      // lw, no stalls: 1,2,3,4,5 then back to 1.
      tick(); expect_st("lw_fetch", 4'd1, VFetch);
      tick(); expect_st("lw_decode", 4'd2, VDecode);
      tick(); expect_st("lw_addr", 4'd3, VMemAddr);
      tick(); expect_st("lw_read", 4'd4, VMemRead);
      tick(); expect_st("lw_wb", 4'd5, VMemWb);
      tick();

      // FETCH stall for one cycle, then sw with three MEM_WRITE stalls.
      u_if.opcode    = 6'b101011;
      u_if.mem_ready = 1'b0;
      expect_st("sw_fetch_stall", 4'd1, VFetchStl);
      tick(); expect_st("sw_fetch_stall2", 4'd1, VFetchStl);
      u_if.mem_ready = 1'b1;
      expect_st("sw_fetch", 4'd1, VFetch);
      tick(); expect_st("sw_decode", 4'd2, VDecode);
      tick(); expect_st("sw_addr", 4'd3, VMemAddr);
      tick();
      u_if.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         expect_st($sformatf("sw_write_stall%0d", i), 4'd6, VMemWrite);
         tick();
      end
      u_if.mem_ready = 1'b1;
      expect_st("sw_write_done", 4'd6, VMemWrite);
      tick();

      // R-type.
      u_if.opcode = 6'b000000;
      expect_st("r_fetch", 4'd1, VFetch);
      tick(); expect_st("r_decode", 4'd2, VDecode);
      u_if.mem_ready = 1'b0;  // ignored outside FETCH/MEM_READ/MEM_WRITE
      tick(); expect_st("r_exec", 4'd7, VExecute);
      u_if.mem_ready = 1'b1;
      tick(); expect_st("r_comp", 4'd8, VRComp);
      tick();

      // beq then j.
      u_if.opcode = 6'b000100;
      expect_st("beq_fetch", 4'd1, VFetch);
      tick(); expect_st("beq_decode", 4'd2, VDecode);
      tick(); expect_st("beq_branch", 4'd9, VBranch);
      tick();
      u_if.opcode = 6'b000010;
      expect_st("j_fetch", 4'd1, VFetch);
      tick(); expect_st("j_decode", 4'd2, VDecode);
      tick(); expect_st("j_jump", 4'd10, VJump);
      tick();

      // addi.
      u_if.opcode = 6'b001000;
      expect_st("addi_fetch", 4'd1, VFetch);
      tick(); expect_st("addi_decode", 4'd2, VDecode);
      tick(); expect_st("addi_exec", 4'd11, VMemAddr);
      tick(); expect_st("addi_wb", 4'd12, VAddiWb);
      tick();

      // Illegal opcode: back to FETCH with a one-cycle illegal_op pulse.
      u_if.opcode = 6'b111111;
      expect_st("ill_fetch", 4'd1, VFetch);
      tick(); expect_st("ill_decode", 4'd2, VDecode);
      tick(); expect_st("ill_pulse", 4'd1, VFetchIll);
      u_if.opcode = 6'b101011;
      tick(); expect_st("ill_cleared", 4'd2, VDecode);

      // sw in flight, async reset between edges drops MemWrite at once.
      tick(); expect_st("rst_addr", 4'd3, VMemAddr);
      tick();
      u_if.mem_ready = 1'b0;
      expect_st("rst_write", 4'd6, VMemWrite);
      #2;
      reset = 1'b1;
      #1;
      check("rst_async_memwrite", 32'(u_if.MemWrite), 32'd0);
      check("rst_async_state", 32'(u_if.state), 32'd0);
      u_if.mem_ready = 1'b1;
      tick(); expect_st("rst_held", 4'd0, VZero);
      @(negedge clk);
      reset = 1'b0;
      tick(); expect_st("rst_first_fetch", 4'd1, VFetch);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
